// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, opcode
// classes, ALU operations, condition codes and flag bit positions.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StUnknown  = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    OpDp     = 2'b00,
    OpMem    = 2'b01,
    OpBranch = 2'b10,
    OpUndef  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluSub = 2'b01,
    AluAnd = 2'b10,
    AluOrr = 2'b11
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    CondEq = 4'd0,
    CondNe = 4'd1,
    CondCs = 4'd2,
    CondCc = 4'd3,
    CondMi = 4'd4,
    CondPl = 4'd5,
    CondVs = 4'd6,
    CondVc = 4'd7,
    CondHi = 4'd8,
    CondLs = 4'd9,
    CondGe = 4'd10,
    CondLt = 4'd11,
    CondGt = 4'd12,
    CondLe = 4'd13,
    CondAl = 4'd14,
    CondNv = 4'd15
  } cond_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Evaluate an ARM condition field against stored NZCV; 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    n = flags[FlagN];
    z = flags[FlagZ];
    c = flags[FlagC];
    v = flags[FlagV];
    case (cond_e'(cond))
      CondEq:  res = z;
      CondNe:  res = ~z;
      CondCs:  res = c;
      CondCc:  res = ~c;
      CondMi:  res = n;
      CondPl:  res = ~n;
      CondVs:  res = v;
      CondVc:  res = ~v;
      CondHi:  res = c & ~z;
      CondLs:  res = ~c | z;
      CondGe:  res = (n == v);
      CondLt:  res = (n != v);
      CondGt:  res = ~z & (n == v);
      CondLe:  res = z | (n != v);
      CondAl:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_controller_cond_logic.sv
// Condition unit: NZCV flags register, condition evaluation, the per-instruction
// condition latch and gating of the architectural write enables.
module mc_controller_cond_logic
  import mc_controller_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       cond_load_i,
  input  logic       pcs_i,
  input  logic       next_pc_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_r_q, cond_ex_r_d;
  logic       cond_ex;

  // Condition result latched in DECODE and flag updates gated by it.
  always_comb begin
    cond_ex     = cond_eval(cond_i, flags_q);
    cond_ex_r_d = cond_load_i ? cond_ex : cond_ex_r_q;
    flags_d     = flags_q;
    if (flag_w_i[1] && cond_ex_r_q) begin
      flags_d[FlagN] = alu_flags_i[FlagN];
      flags_d[FlagZ] = alu_flags_i[FlagZ];
    end
    if (flag_w_i[0] && cond_ex_r_q) begin
      flags_d[FlagC] = alu_flags_i[FlagC];
      flags_d[FlagV] = alu_flags_i[FlagV];
    end
  end

  // Flags and condition latch, cleared by asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q     <= 4'b0000;
      cond_ex_r_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  // Reset masks enables combinationally so an aborted cycle cannot write.
  always_comb begin
    pc_write_o  = rst_ni & ((pcs_i & cond_ex_r_q) | next_pc_i);
    reg_write_o = rst_ni & reg_w_i & cond_ex_r_q;
    mem_write_o = rst_ni & mem_w_i & cond_ex_r_q;
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: instruction-sequencing FSM, ALU decoder and
// instruction decode, with condition checking in the cond_logic sub-block.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl,
  output logic [3:0]   state_o
);

  state_e    state_q, state_d;
  op_e       op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;

  logic      ir_write, next_pc, reg_w, mem_w, branch, alu_op;
  logic      adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  alu_ctrl_e alu_control;
  logic [1:0] flag_w;
  logic      pcs;
  logic      unused_rn;

  assign cond      = Instr[31:28];
  assign op        = op_e'(Instr[27:26]);
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpMem:    state_d = StMemAdr;
          OpDp:     state_d = funct[5] ? StExecuteI : StExecuteR;
          OpBranch: state_d = StBranch;
          default:  state_d = StUnknown;
        endcase
      end
      StMemAdr:   state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:    state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Moore control outputs per state.
  always_comb begin
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    unique case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StDecode: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StMemAdr: alu_src_b = 2'b01;
      StMemRd:  adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      StMemWr: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      StExecuteR: alu_op = 1'b1;
      StExecuteI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      StAluWb: reg_w = 1'b1;
      StBranch: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; only add/sub produce meaningful C and V.
  always_comb begin
    alu_control = AluAdd;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: alu_control = AluAdd;
        4'b0010: alu_control = AluSub;
        4'b0000: alu_control = AluAnd;
        4'b1100: alu_control = AluOrr;
        default: alu_control = AluAdd;
      endcase
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ((alu_control == AluAdd) || (alu_control == AluSub));
    end
  end

  // Writes targeting R15 redirect the PC.
  always_comb begin
    pcs = ((rd == 4'd15) & reg_w) | branch;
  end

  mc_controller_cond_logic u_cond_logic (
    .clk_i       (clk),
    .rst_ni      (reset),
    .cond_i      (cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flag_w),
    .cond_load_i (state_q == StDecode),
    .pcs_i       (pcs),
    .next_pc_i   (next_pc),
    .reg_w_i     (reg_w),
    .mem_w_i     (mem_w),
    .pc_write_o  (PCWrite),
    .reg_write_o (RegWrite),
    .mem_write_o (MemWrite)
  );

  assign IRWrite    = ir_write & reset;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ResultSrc  = result_src;
  assign ALUControl = alu_control;
  assign ImmSrc     = Instr[27:26];
  assign RegSrc     = {op == OpMem, op == OpBranch};
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: an instruction-level model predicts every cycle's
// state and controls; a negedge process compares them, and directed literal
// checks pin the model on the key cycles of each instruction.
module tb_mc_controller;
  import mc_controller_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0]   state_o;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] en;    // {PCWrite, MemWrite, RegWrite, IRWrite}
    logic       adr;
    logic [1:0] regsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] aluc;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       obs_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] m_flags = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // ARM condition truth from NZCV.
  function automatic logic m_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] m_alu(input logic [5:0] funct);
    case (funct[4:1])
      4'd4:    return 2'b00;
      4'd2:    return 2'b01;
      4'd0:    return 2'b10;
      4'd12:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Expected outputs for one cycle of an instruction.
  function automatic rec_t m_ctrl(input state_e s, input logic [31:0] ins, input logic pass);
    rec_t r;
    logic [1:0] op;
    logic       rd15;
    op       = ins[27:26];
    rd15     = (ins[15:12] == 4'hF);
    r        = '0;
    r.st     = s;
    r.imm    = op;
    r.regsrc = {op == 2'b01, op == 2'b10};
    case (s)
      StFetch:    begin r.en = 4'b1001; r.srca = 2'b01; r.srcb = 2'b10; r.res = 2'b10; end
      StDecode:   begin r.srca = 2'b01; r.srcb = 2'b10; r.res = 2'b10; end
      StMemAdr:   r.srcb = 2'b01;
      StMemRd:    r.adr = 1'b1;
      StMemWb:    begin r.res = 2'b01; r.en = {pass && rd15, 1'b0, pass, 1'b0}; end
      StMemWr:    begin r.adr = 1'b1; r.en = {1'b0, pass, 2'b00}; end
      StExecuteR: r.aluc = m_alu(ins[25:20]);
      StExecuteI: begin r.srcb = 2'b01; r.aluc = m_alu(ins[25:20]); end
      StAluWb:    r.en = {pass && rd15, 1'b0, pass, 1'b0};
      StBranch:   begin r.srca = 2'b10; r.srcb = 2'b01; r.res = 2'b10; r.en = {pass, 3'b000}; end
      default:    ;
    endcase
    return r;
  endfunction

  // Drive one instruction (optionally truncated) and queue per-cycle expectations.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int max_cyc);
    state_e     seq[$];
    logic       pass;
    logic [1:0] op;
    logic [5:0] funct;
    op    = ins[27:26];
    funct = ins[25:20];
    pass  = m_pass(ins[31:28], m_flags);
    seq   = {StFetch, StDecode};
    case (op)
      2'b00: begin
        seq.push_back(funct[5] ? StExecuteI : StExecuteR);
        seq.push_back(StAluWb);
      end
      2'b01: begin
        seq.push_back(StMemAdr);
        if (funct[0]) begin
          seq.push_back(StMemRd);
          seq.push_back(StMemWb);
        end else begin
          seq.push_back(StMemWr);
        end
      end
      2'b10:   seq.push_back(StBranch);
      default: seq.push_back(StUnknown);
    endcase
    obs_q.delete();
    for (int i = 0; i < seq.size() && i < max_cyc; i++) begin
      Instr    = ins[31:12];
      ALUFlags = af;
      exp_q.push_back(m_ctrl(seq[i], ins, pass));
      @(posedge clk);
      #1;
    end
    if (max_cyc >= seq.size() && op == 2'b00 && funct[0] && pass) begin
      m_flags[3:2] = af[3:2];
      if (m_alu(funct) inside {2'b00, 2'b01}) m_flags[1:0] = af[1:0];
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e, o;
      e        = exp_q.pop_front();
      o.st     = state_o;
      o.en     = {PCWrite, MemWrite, RegWrite, IRWrite};
      o.adr    = AdrSrc;
      o.regsrc = RegSrc;
      o.srca   = ALUSrcA;
      o.srcb   = ALUSrcB;
      o.res    = ResultSrc;
      o.imm    = ImmSrc;
      o.aluc   = ALUControl;
      obs_q.push_back(o);
      chk("state", 32'(o.st), 32'(e.st));
      chk("enables", 32'(o.en), 32'(e.en));
      chk("adrsrc", 32'(o.adr), 32'(e.adr));
      chk("regsrc", 32'(o.regsrc), 32'(e.regsrc));
      chk("alusrca", 32'(o.srca), 32'(e.srca));
      chk("alusrcb", 32'(o.srcb), 32'(e.srcb));
      chk("resultsrc", 32'(o.res), 32'(e.res));
      chk("immsrc", 32'(o.imm), 32'(e.imm));
      chk("alucontrol", 32'(o.aluc), 32'(e.aluc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t rr;
    reset    = 1'b0;
    Instr    = '0;
    ALUFlags = 4'b0000;
    @(posedge clk);
    #1;
    // Held in reset: FETCH with all enables masked.
    rr    = m_ctrl(StFetch, 32'h0, 1'b0);
    rr.en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rr);
      @(posedge clk);
      #1;
    end
    chk("reset_state", 32'(state_o), 32'(StFetch));
    reset = 1'b1;

    // ADD R2,R0,#5
    run_instr(32'hE2802005, 4'b0000, 99);
    chk("add_len", 32'(obs_q.size()), 32'd4);
    chk("add_fetch_en", 32'(obs_q[0].en), 32'b1001);
    chk("add_fetch_srcb", 32'(obs_q[0].srcb), 32'b10);
    chk("add_ei_state", 32'(obs_q[2].st), 32'(StExecuteI));
    chk("add_aluwb_regwrite", 32'(obs_q[3].en), 32'b0010);

    // LDR R1,[R0,#4]
    run_instr(32'hE5901004, 4'b0000, 99);
    chk("ldr_len", 32'(obs_q.size()), 32'd5);
    chk("ldr_memrd_adr", 32'(obs_q[3].adr), 32'd1);
    chk("ldr_memwb_res", 32'(obs_q[4].res), 32'b01);
    chk("ldr_memwb_en", 32'(obs_q[4].en), 32'b0010);

    // STR R1,[R0,#4]
    run_instr(32'hE5801004, 4'b0000, 99);
    chk("str_len", 32'(obs_q.size()), 32'd4);
    chk("str_memwr_en", 32'(obs_q[3].en), 32'b0100);

    // SUBS R0,R0,R0 sets Z and C
    run_instr(32'hE0500000, 4'b0110, 99);
    chk("subs_aluc", 32'(obs_q[2].aluc), 32'b01);
    chk("subs_model_flags", 32'(m_flags), 32'b0110);

    run_instr(32'h0A000001, 4'b0000, 99);   // BEQ taken
    chk("beq_len", 32'(obs_q.size()), 32'd3);
    chk("beq_pcwrite", 32'(obs_q[2].en), 32'b1000);
    run_instr(32'h1A000001, 4'b0000, 99);   // BNE not taken
    chk("bne_pcwrite", 32'(obs_q[2].en), 32'b0000);

    // ADDNE with Z=1: full length, no write
    run_instr(32'h12802005, 4'b0000, 99);
    chk("addne_len", 32'(obs_q.size()), 32'd4);
    chk("addne_regwrite", 32'(obs_q[3].en), 32'b0000);

    // ANDS with ALUFlags 1011: NZ<=10, CV keeps 10
    run_instr(32'hE0100000, 4'b1011, 99);
    chk("ands_aluc", 32'(obs_q[2].aluc), 32'b10);
    chk("ands_model_flags", 32'(m_flags), 32'b1010);
    run_instr(32'h6A000001, 4'b0000, 99);   // BVS: V stayed 0
    chk("bvs_pcwrite", 32'(obs_q[2].en), 32'b0000);
    run_instr(32'h4A000001, 4'b0000, 99);   // BMI: N now 1
    chk("bmi_pcwrite", 32'(obs_q[2].en), 32'b1000);
    run_instr(32'h2A000001, 4'b0000, 99);   // BCS: C kept 1
    chk("bcs_pcwrite", 32'(obs_q[2].en), 32'b1000);
    run_instr(32'h0A000001, 4'b0000, 99);   // BEQ: Z now 0

    // ORR R0,R0,R0 register form
    run_instr(32'hE1800000, 4'b0000, 99);
    chk("orr_aluc", 32'(obs_q[2].aluc), 32'b11);

    // ADD PC,PC,#0
    run_instr(32'hE28FF000, 4'b0000, 99);
    chk("addpc_aluwb_en", 32'(obs_q[3].en), 32'b1010);

    // Op=11 undefined
    run_instr(32'hEC000000, 4'b0000, 99);
    chk("undef_len", 32'(obs_q.size()), 32'd3);
    chk("undef_state", 32'(obs_q[2].st), 32'(StUnknown));

    // Cond=1111 never executes
    run_instr(32'hF2802005, 4'b0000, 99);
    chk("nv_regwrite", 32'(obs_q[3].en), 32'b0000);

    // Reset asserted during MEMRD
    run_instr(32'hE5901004, 4'b0000, 3);
    chk("abort_pre_state", 32'(state_o), 32'(StMemRd));
    #2;
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(state_o), 32'(StFetch));
    chk("abort_en", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'b0000);
    m_flags = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(32'hE2802005, 4'b0000, 99);
    chk("recover_len", 32'(obs_q.size()), 32'd4);
    chk("recover_regwrite", 32'(obs_q[3].en), 32'b0010);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
